brc_pipe: RTL and testbench

BRC_PIPE -- requirements
Module: brc_pipe

---
 rtl/brc_pipe_if.sv | 39 +++
 rtl/brc_pipe.sv | 157 +++++++++++++++
 tb/tb_brc_pipe.sv | 322 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/brc_pipe_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : brc_pipe_if                                            |
// | Description : Request/result handshake bundle for the branch        |
// |               comparator pipeline (operands, tag, result fields).    |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
interface brc_pipe_if #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 5
);
  logic             i_valid;
  logic             o_ready;
  logic [WIDTH-1:0] i_rs1_data;
  logic [WIDTH-1:0] i_rs2_data;
  logic [2:0]       i_funct3;
  logic [TAG_W-1:0] i_tag;

  logic             o_valid;
  logic             i_ready;
  logic             o_taken;
  logic             o_equal;
  logic             o_less;
  logic             o_illegal;
  logic [TAG_W-1:0] o_tag;

  // Requester / result consumer side
  modport master (
    output i_valid, i_rs1_data, i_rs2_data, i_funct3, i_tag, i_ready,
    input  o_ready, o_valid, o_taken, o_equal, o_less, o_illegal, o_tag
  );

  // Comparator pipeline side
  modport slave (
    input  i_valid, i_rs1_data, i_rs2_data, i_funct3, i_tag, i_ready,
    output o_ready, o_valid, o_taken, o_equal, o_less, o_illegal, o_tag
  );
endinterface
`default_nettype wire

// File: rtl/brc_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : brc_pipe                                               |
// | Description : Two-stage RISC-V branch comparator. S1 registers       |
// |               per-chunk equal/less flags, S2 merges them into the    |
// |               equal/less/taken/illegal result. Valid/ready on both   |
// |               sides, one op per cycle.                               |
// | Option      : BRC_PIPE_FLUSH_EN adds i_flush (empties both stages).  |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module brc_pipe #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8,
  parameter int TAG_W = 5
) (
  input  logic      i_clk,
  input  logic      i_rst_n,
  brc_pipe_if.slave bus
`ifdef BRC_PIPE_FLUSH_EN
  ,
  input  logic      i_flush
`endif
);

  localparam int c_N_SLICE = WIDTH / CHUNK;

  logic                 w_flush;
  logic                 w_s2_adv;
  logic                 w_s1_adv;
  logic                 w_ready;
  logic                 w_accept;
  logic [c_N_SLICE-1:0] w_slice_eq;
  logic [c_N_SLICE-1:0] w_slice_lt;

  logic                 r_s1_valid;
  logic [c_N_SLICE-1:0] r_s1_eq;
  logic [c_N_SLICE-1:0] r_s1_lt;
  logic                 r_s1_msb1;
  logic                 r_s1_msb2;
  logic [2:0]           r_s1_f3;
  logic [TAG_W-1:0]     r_s1_tag;

  logic                 w_equal;
  logic                 w_mag_lt;
  logic                 w_less;
  logic                 w_illegal;
  logic                 w_taken;

  logic                 r_s2_valid;
  logic                 r_taken;
  logic                 r_equal;
  logic                 r_less;
  logic                 r_illegal;
  logic [TAG_W-1:0]     r_tag;

`ifdef BRC_PIPE_FLUSH_EN
  assign w_flush = i_flush;
`else
  assign w_flush = 1'b0;
`endif

  // Stall chain: each stage moves when the one after it can take its content.
  // o_ready depends only on state, i_ready and flush, never on i_valid.
  assign w_s2_adv = !r_s2_valid || bus.i_ready;
  assign w_s1_adv = !r_s1_valid || w_s2_adv;
  assign w_ready  = w_s1_adv && !w_flush;
  assign w_accept = bus.i_valid && w_ready;

  // Leaf comparators, one unsigned equal/less pair per chunk
  generate
    for (genvar k = 0; k < c_N_SLICE; k++) begin : g_slice
      assign w_slice_eq[k] = (bus.i_rs1_data[k*CHUNK +: CHUNK] == bus.i_rs2_data[k*CHUNK +: CHUNK]);
      assign w_slice_lt[k] = (bus.i_rs1_data[k*CHUNK +: CHUNK] <  bus.i_rs2_data[k*CHUNK +: CHUNK]);
    end
  endgenerate

  // S1 occupancy: cleared by reset/flush, otherwise refilled from the input when S1 moves
  always_ff @(posedge i_clk) begin
    if (!i_rst_n || w_flush) begin
      r_s1_valid <= 1'b0;
    end else if (w_s1_adv) begin
      r_s1_valid <= w_accept;
    end
  end

  // S1 payload: slice flags, sign bits and sideband captured on acceptance
  always_ff @(posedge i_clk) begin
    if (w_accept) begin
      r_s1_eq   <= w_slice_eq;
      r_s1_lt   <= w_slice_lt;
      r_s1_msb1 <= bus.i_rs1_data[WIDTH-1];
      r_s1_msb2 <= bus.i_rs2_data[WIDTH-1];
      r_s1_f3   <= bus.i_funct3;
      r_s1_tag  <= bus.i_tag;
    end
  end

  // Merge slice flags; the highest differing slice decides the magnitude order
  always_comb begin
    w_equal  = &r_s1_eq;
    w_mag_lt = 1'b0;
    for (int k = 0; k < c_N_SLICE; k++) begin
      if (!r_s1_eq[k]) begin
        w_mag_lt = r_s1_lt[k];
      end
    end
    // funct3 bit 1 clear selects the signed group (BEQ/BNE/BLT/BGE)
    if (!r_s1_f3[1] && (r_s1_msb1 != r_s1_msb2)) begin
      w_less = r_s1_msb1;
    end else begin
      w_less = w_mag_lt;
    end
    w_illegal = (r_s1_f3[2:1] == 2'b01);
    case (r_s1_f3)
      3'b000:         w_taken = w_equal;
      3'b001:         w_taken = !w_equal;
      3'b100, 3'b110: w_taken = w_less;
      3'b101, 3'b111: w_taken = !w_less;
      default:        w_taken = 1'b0;
    endcase
  end

  // S2: output register, held while the consumer stalls
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_s2_valid <= 1'b0;
      r_taken    <= 1'b0;
      r_equal    <= 1'b0;
      r_less     <= 1'b0;
      r_illegal  <= 1'b0;
      r_tag      <= '0;
    end else begin
      if (w_flush) begin
        r_s2_valid <= 1'b0;
      end else if (w_s2_adv) begin
        r_s2_valid <= r_s1_valid;
      end
      if (w_s2_adv && r_s1_valid && !w_flush) begin
        r_taken   <= w_taken;
        r_equal   <= w_equal;
        r_less    <= w_less;
        r_illegal <= w_illegal;
        r_tag     <= r_s1_tag;
      end
    end
  end

  assign bus.o_ready   = w_ready;
  assign bus.o_valid   = r_s2_valid;
  assign bus.o_taken   = r_taken;
  assign bus.o_equal   = r_equal;
  assign bus.o_less    = r_less;
  assign bus.o_illegal = r_illegal;
  assign bus.o_tag     = r_tag;

endmodule
`default_nettype wire

// File: tb/tb_brc_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_brc_pipe                                            |
// | Description : Self-checking bench for brc_pipe (directed scenarios   |
// |               plus randomized traffic against a queue model).        |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module tb_brc_pipe;
  localparam int W = 32;
  localparam int T = 5;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
`ifdef BRC_PIPE_FLUSH_EN
  logic flush = 1'b0;
`endif
  int total = 0;
  int bad   = 0;

  brc_pipe_if #(.WIDTH(W), .TAG_W(T)) bus ();

  brc_pipe #(.WIDTH(W), .CHUNK(8), .TAG_W(T)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
`ifdef BRC_PIPE_FLUSH_EN
    ,
    .i_flush (flush)
`endif
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  always #5 clk = ~clk;

  // Reference: result fields {tag, taken, equal, less, illegal} from the ISA rules
  function automatic logic [8:0] ref_result(input logic [31:0] a, input logic [31:0] b,
                                            input logic [2:0] f3, input logic [4:0] tag);
    logic eq, lt, tk, il;
    eq = (a == b);
    il = (f3 == 3'b010) || (f3 == 3'b011);
    if (f3 == 3'b110 || f3 == 3'b111 || il) lt = (a < b);
    else                                     lt = ($signed(a) < $signed(b));
    case (f3)
      3'd0:       tk = eq;
      3'd1:       tk = !eq;
      3'd4, 3'd6: tk = lt;
      3'd5, 3'd7: tk = !lt;
      default:    tk = 1'b0;
    endcase
    return {tag, tk, eq, lt, il};
  endfunction

  function automatic logic [8:0] obs();
    return {bus.o_tag, bus.o_taken, bus.o_equal, bus.o_less, bus.o_illegal};
  endfunction

  task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] b,
                       input logic [2:0] f3, input logic [4:0] tag);
    bus.i_valid    = v;
    bus.i_rs1_data = a;
    bus.i_rs2_data = b;
    bus.i_funct3   = f3;
    bus.i_tag      = tag;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.i_ready = 1'b1;
    drive(1'b0, 32'd0, 32'd0, 3'd0, 5'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++;
    if (bus.o_valid !== 1'b0) begin
      bad++; $display("FAIL reset_valid: got %b expected 0", bus.o_valid);
    end
    total++;
    if (obs() !== 9'd0) begin
      bad++; $display("FAIL reset_fields: got %h expected 000", obs());
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    total++;
    if (bus.o_ready !== 1'b1) begin
      bad++; $display("FAIL reset_ready: got %b expected 1", bus.o_ready);
    end
  endtask

  // One op through an idle pipe; expected fields are given by the caller
  task automatic test_directed(input string name, input logic [2:0] f3, input logic [31:0] a,
                               input logic [31:0] b, input logic [4:0] tag, input logic tk,
                               input logic eq, input logic lt, input logic il);
    bus.i_ready = 1'b1;
    @(negedge clk);
    drive(1'b1, a, b, f3, tag);
    #1;
    total++;
    if (bus.o_ready !== 1'b1) begin
      bad++; $display("FAIL %s_ready: got %b expected 1", name, bus.o_ready);
    end
    @(negedge clk);
    drive(1'b0, 32'd0, 32'd0, 3'd0, 5'd0);
    total++;
    if (bus.o_valid !== 1'b0) begin
      bad++; $display("FAIL %s_early: got o_valid=%b expected 0", name, bus.o_valid);
    end
    @(negedge clk);
    total++;
    if (bus.o_valid !== 1'b1) begin
      bad++; $display("FAIL %s_valid: got %b expected 1", name, bus.o_valid);
    end
    total++;
    if (obs() !== {tag, tk, eq, lt, il}) begin
      bad++; $display("FAIL %s_fields: got %h expected %h", name, obs(), {tag, tk, eq, lt, il});
    end
    @(negedge clk);
    total++;
    if (bus.o_valid !== 1'b0) begin
      bad++; $display("FAIL %s_dup: got o_valid=%b expected 0", name, bus.o_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [8:0] ea, eb, ec;
    ea = ref_result(32'd7, 32'd7, 3'b000, 5'd1);
    eb = ref_result(32'd3, 32'd9, 3'b110, 5'd2);
    ec = ref_result(32'h8000_0000, 32'd1, 3'b101, 5'd4);
    @(negedge clk);
    bus.i_ready = 1'b0;
    drive(1'b1, 32'd7, 32'd7, 3'b000, 5'd1);
    #1;
    total++;
    if (bus.o_ready !== 1'b1) begin bad++; $display("FAIL b2b_acc_a: got %b expected 1", bus.o_ready); end
    @(negedge clk);
    drive(1'b1, 32'd3, 32'd9, 3'b110, 5'd2);
    #1;
    total++;
    if (bus.o_ready !== 1'b1) begin bad++; $display("FAIL b2b_acc_b: got %b expected 1", bus.o_ready); end
    @(negedge clk);
    drive(1'b1, 32'h8000_0000, 32'd1, 3'b101, 5'd4);
    for (int i = 0; i < 2; i++) begin
      #1;
      total++;
      if (bus.o_ready !== 1'b0) begin bad++; $display("FAIL b2b_block_c: got %b expected 0", bus.o_ready); end
      total++;
      if (bus.o_valid !== 1'b1 || obs() !== ea) begin
        bad++; $display("FAIL b2b_hold_a: got v=%b %h expected v=1 %h", bus.o_valid, obs(), ea);
      end
      @(negedge clk);
    end
    bus.i_ready = 1'b1;
    #1;
    total++;
    if (bus.o_ready !== 1'b1) begin bad++; $display("FAIL b2b_release: got %b expected 1", bus.o_ready); end
    total++;
    if (bus.o_valid !== 1'b1 || obs() !== ea) begin
      bad++; $display("FAIL b2b_out_a: got v=%b %h expected v=1 %h", bus.o_valid, obs(), ea);
    end
    @(negedge clk);
    drive(1'b0, 32'd0, 32'd0, 3'd0, 5'd0);
    total++;
    if (bus.o_valid !== 1'b1 || obs() !== eb) begin
      bad++; $display("FAIL b2b_out_b: got v=%b %h expected v=1 %h", bus.o_valid, obs(), eb);
    end
    @(negedge clk);
    total++;
    if (bus.o_valid !== 1'b1 || obs() !== ec) begin
      bad++; $display("FAIL b2b_out_c: got v=%b %h expected v=1 %h", bus.o_valid, obs(), ec);
    end
    @(negedge clk);
    total++;
    if (bus.o_valid !== 1'b0) begin bad++; $display("FAIL b2b_drain: got %b expected 0", bus.o_valid); end
  endtask

  task automatic test_reset_midflight();
    @(negedge clk);
    bus.i_ready = 1'b0;
    drive(1'b1, 32'd1, 32'd2, 3'b100, 5'd9);
    @(negedge clk);
    drive(1'b1, 32'd5, 32'd5, 3'b000, 5'd10);
    @(negedge clk);
    drive(1'b0, 32'd0, 32'd0, 3'd0, 5'd0);
    total++;
    if (bus.o_valid !== 1'b1) begin bad++; $display("FAIL rstmid_loaded: got %b expected 1", bus.o_valid); end
    rst_n = 1'b0;
    @(negedge clk);
    total++;
    if (bus.o_valid !== 1'b0 || obs() !== 9'd0) begin
      bad++; $display("FAIL rstmid_clear: got v=%b %h expected v=0 000", bus.o_valid, obs());
    end
    rst_n = 1'b1;
    bus.i_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      total++;
      if (bus.o_valid !== 1'b0) begin bad++; $display("FAIL rstmid_stale: got %b expected 0", bus.o_valid); end
    end
  endtask

`ifdef BRC_PIPE_FLUSH_EN
  task automatic test_flush();
    logic [8:0] ed;
    ed = ref_result(32'd20, 32'd10, 3'b111, 5'd17);
    @(negedge clk);
    bus.i_ready = 1'b0;
    drive(1'b1, 32'd1, 32'd1, 3'b000, 5'd11);
    @(negedge clk);
    drive(1'b1, 32'd2, 32'd3, 3'b110, 5'd12);
    @(negedge clk);
    bus.i_ready = 1'b1;
    drive(1'b1, 32'd4, 32'd4, 3'b001, 5'd13);
    flush = 1'b1;
    #1;
    total++;
    if (bus.o_ready !== 1'b0) begin bad++; $display("FAIL flush_ready: got %b expected 0", bus.o_ready); end
    @(negedge clk);
    flush = 1'b0;
    drive(1'b0, 32'd0, 32'd0, 3'd0, 5'd0);
    for (int i = 0; i < 4; i++) begin
      total++;
      if (bus.o_valid !== 1'b0) begin bad++; $display("FAIL flush_gone: got %b expected 0", bus.o_valid); end
      @(negedge clk);
    end
    drive(1'b1, 32'd20, 32'd10, 3'b111, 5'd17);
    @(negedge clk);
    drive(1'b0, 32'd0, 32'd0, 3'd0, 5'd0);
    @(negedge clk);
    total++;
    if (bus.o_valid !== 1'b1 || obs() !== ed) begin
      bad++; $display("FAIL flush_after: got v=%b %h expected v=1 %h", bus.o_valid, obs(), ed);
    end
  endtask
`endif

  // Random traffic and backpressure against an in-order queue of expected results
  task automatic test_random(input int n);
    logic [8:0]  q[$];
    int          qc[$];
    logic [31:0] a, b;
    logic [2:0]  f3;
    logic [4:0]  tag;
    logic        exp_valid;
    int          s;
    for (int c = 0; c < n + 12; c++) begin
      @(negedge clk);
      a   = $urandom;
      b   = $urandom;
      f3  = 3'($urandom_range(0, 7));
      tag = 5'($urandom);
      case ($urandom_range(0, 3))
        0: b = a;
        1: begin b = a; s = $urandom_range(0, 3); b[s*8 +: 8] = 8'($urandom); end
        2: b = a ^ 32'h8000_0000;
        default: ;
      endcase
      if (c < n) begin
        drive(($urandom_range(0, 9) < 7), a, b, f3, tag);
        bus.i_ready = ($urandom_range(0, 9) < 7);
      end else begin
        drive(1'b0, a, b, f3, tag);
        bus.i_ready = 1'b1;
      end
      #1;
      total++;
      if (bus.o_ready !== ((q.size() < 2) || bus.i_ready)) begin
        bad++; $display("FAIL rnd_ready: got %b expected %b (c=%0d)", bus.o_ready,
                        ((q.size() < 2) || bus.i_ready), c);
      end
      exp_valid = (q.size() > 0) && (qc[0] <= c - 2);
      total++;
      if (bus.o_valid !== exp_valid) begin
        bad++; $display("FAIL rnd_valid: got %b expected %b (c=%0d)", bus.o_valid, exp_valid, c);
      end
      if (bus.o_valid && q.size() > 0) begin
        total++;
        if (obs() !== q[0]) begin
          bad++; $display("FAIL rnd_fields: got %h expected %h (c=%0d)", obs(), q[0], c);
        end
        if (bus.i_ready) begin
          void'(q.pop_front());
          void'(qc.pop_front());
        end
      end
      if (bus.i_valid && bus.o_ready) begin
        q.push_back(ref_result(a, b, f3, tag));
        qc.push_back(c);
      end
    end
    total++;
    if (q.size() != 0) begin
      bad++; $display("FAIL rnd_drain: got %0d ops left expected 0", q.size());
    end
  endtask

  initial begin
    bus.i_ready = 1'b1;
    drive(1'b0, 32'd0, 32'd0, 3'd0, 5'd0);
    test_reset();
    test_directed("blt",   3'b100, 32'hFFFF_FFFF, 32'h0000_0001, 5'd3, 1'b1, 1'b0, 1'b1, 1'b0);
    test_directed("bltu",  3'b110, 32'hFFFF_FFFF, 32'h0000_0001, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0);
    test_directed("bgeu",  3'b111, 32'hFFFF_FFFF, 32'h0000_0001, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0);
    test_directed("bne",   3'b001, 32'h1234_5678, 32'h1234_5678, 5'd7, 1'b0, 1'b1, 1'b0, 1'b0);
    test_directed("beq",   3'b000, 32'h1234_5678, 32'h1234_5679, 5'd8, 1'b0, 1'b0, 1'b1, 1'b0);
    test_directed("illeg", 3'b010, 32'd5,         32'd9,         5'd31, 1'b0, 1'b0, 1'b1, 1'b1);
    test_back_to_back();
    test_reset_midflight();
`ifdef BRC_PIPE_FLUSH_EN
    test_flush();
`endif
    test_random(800);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Hard stop in case a scenario never returns
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion before 200000");
    $fatal(1);
  end

endmodule
`default_nettype wire
